// File: rtl/winner_pkg.sv
// Shared cell codes, winner ids and FSM state encoding for the end-of-game sequencer.
package winner_pkg;

  localparam int CELL_EMPTY = 0;
  localparam int CELL_SHIP  = 1;
  localparam int CELL_HIT   = 2;
  localparam int CELL_MISS  = 3;

  localparam logic [1:0] WIN_NONE   = 2'd0;
  localparam logic [1:0] WIN_PLAYER = 2'd1;
  localparam logic [1:0] WIN_PC     = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_DECIDE,
    S_SHOW,
    S_HOLD,
    S_CLEAR
  } state_t;

endpackage

// File: rtl/winner_ctrl_blink.sv
// Blink half-period timer: reloads on start, ticks every BLINK_CYCLES enabled cycles
// and counts completed half-periods.
module blink_timer #(
  parameter int BLINK_CYCLES  = 25_000_000,
  parameter int BLINK_TOGGLES = 6,
  parameter int TW            = $clog2(BLINK_TOGGLES + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          en,
  output logic          tick,
  output logic [TW-1:0] toggles
);

  localparam int CNT_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(BLINK_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = en && (cnt == '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt     <= '0;
      toggles <= '0;
    end else if (start) begin
      cnt     <= RELOAD;
      toggles <= '0;
    end else if (en) begin
      if (cnt == '0) begin
        cnt     <= RELOAD;
        toggles <= toggles + 1'b1;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/winner_ctrl.sv
// End-of-game sequencer: scans both boards after each shot, declares a winner,
// drives the blink/hold display and issues the board clear on new_game.
module winner_ctrl
  import winner_pkg::*;
#(
  parameter int N             = 5,
  parameter int CW            = 3,
  parameter int BLINK_CYCLES  = 25_000_000,
  parameter int BLINK_TOGGLES = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          check,
  input  logic          new_game,
  output logic [2:0]    scan_row,
  output logic [2:0]    scan_col,
  input  logic [CW-1:0] player_cell,
  input  logic [CW-1:0] pc_cell,
  output logic [1:0]    win_id,
  output logic          win_enable,
  output logic          busy,
  output logic          game_over
);

  localparam int CNT_W = $clog2(N * N + 1);
  localparam int TW    = $clog2(BLINK_TOGGLES + 1);
  localparam logic [2:0]    LAST     = 3'(N - 1);
  localparam logic [CW-1:0] SHIP     = CW'(CELL_SHIP);
  localparam logic [TW-1:0] LAST_TGL = TW'(BLINK_TOGGLES - 1);

  state_t           state;
  logic [2:0]       row, col;
  logic [CNT_W-1:0] player_left, pc_left;
  logic             pending;
  logic [1:0]       winner;
  logic             tick;
  logic [TW-1:0]    toggles;

  assign scan_row = row;
  assign scan_col = col;

  // Reloaded while deciding so the first half-period starts exactly on SHOW entry.
  blink_timer #(
    .BLINK_CYCLES (BLINK_CYCLES),
    .BLINK_TOGGLES(BLINK_TOGGLES),
    .TW           (TW)
  ) u_blink (
    .clk    (clk),
    .rst    (rst),
    .start  (state == S_DECIDE),
    .en     (state == S_SHOW),
    .tick   (tick),
    .toggles(toggles)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      row         <= '0;
      col         <= '0;
      player_left <= '0;
      pc_left     <= '0;
      pending     <= 1'b0;
      winner      <= WIN_NONE;
      win_id      <= WIN_NONE;
      win_enable  <= 1'b0;
      busy        <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (check || pending) begin
            state       <= S_SCAN;
            row         <= '0;
            col         <= '0;
            player_left <= '0;
            pc_left     <= '0;
            pending     <= 1'b0;
            busy        <= 1'b1;
          end
        end
        S_SCAN: begin
          if (check) pending <= 1'b1;
          player_left <= player_left + CNT_W'(player_cell == SHIP);
          pc_left     <= pc_left + CNT_W'(pc_cell == SHIP);
          if (col == LAST) begin
            col <= '0;
            if (row == LAST) begin
              row   <= '0;
              state <= S_DECIDE;
            end else begin
              row <= row + 3'd1;
            end
          end else begin
            col <= col + 3'd1;
          end
        end
        S_DECIDE: begin
          if (check) pending <= 1'b1;
          busy <= 1'b0;
          // An empty pc board wins for the player even if both boards are empty.
          if (pc_left == '0 || player_left == '0) begin
            winner     <= (pc_left == '0) ? WIN_PLAYER : WIN_PC;
            win_id     <= (pc_left == '0) ? WIN_PLAYER : WIN_PC;
            win_enable <= 1'b1;
            game_over  <= 1'b1;
            state      <= S_SHOW;
          end else begin
            state <= S_IDLE;
          end
        end
        S_SHOW, S_HOLD: begin
          if (new_game) begin
            state     <= S_CLEAR;
            win_id    <= WIN_NONE;
            game_over <= 1'b0;
          end else if (state == S_SHOW && tick) begin
            if (toggles == LAST_TGL) begin
              state  <= S_HOLD;
              win_id <= winner;
            end else begin
              win_id <= (win_id == WIN_NONE) ? winner : WIN_NONE;
            end
          end
        end
        S_CLEAR: begin
          win_enable <= 1'b0;
          pending    <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_winner_ctrl.sv
// Randomized and directed bench for winner_ctrl against a cycle-level behavioural model.
module tb_winner_ctrl;

  localparam int BC = 4;
  localparam int BT = 6;

  logic       clk, rst, check, new_game;
  logic [2:0] scan_row, scan_col, player_cell, pc_cell;
  logic [1:0] win_id;
  logic       win_enable, busy, game_over;

  logic [2:0] pb  [25];
  logic [2:0] pcb [25];

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  winner_ctrl #(.N(5), .CW(3), .BLINK_CYCLES(BC), .BLINK_TOGGLES(BT)) dut (
    .clk(clk), .rst(rst), .check(check), .new_game(new_game),
    .scan_row(scan_row), .scan_col(scan_col),
    .player_cell(player_cell), .pc_cell(pc_cell),
    .win_id(win_id), .win_enable(win_enable), .busy(busy), .game_over(game_over)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  always_comb begin
    player_cell = '0;
    pc_cell     = '0;
    if (scan_row < 3'd5 && scan_col < 3'd5) begin
      player_cell = pb[int'(scan_row) * 5 + int'(scan_col)];
      pc_cell     = pcb[int'(scan_row) * 5 + int'(scan_col)];
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", name, got, exp);
    end
  endtask

  function automatic int ships(input bit pc);
    int n = 0;
    for (int i = 0; i < 25; i++)
      if ((pc ? pcb[i] : pb[i]) == 3'd1) n++;
    return n;
  endfunction

  // Model phases: 0 idle, 1 scan, 2 decide, 3 show, 4 hold, 5 clear.
  // m_t is the cell index while scanning and the elapsed cycle while blinking.
  int m_st = 0, m_t = 0, m_pend = 0, m_win = 0;

  always @(posedge clk) begin
    if (!rst) begin
      m_st <= 0; m_t <= 0; m_pend <= 0; m_win <= 0;
    end else begin
      case (m_st)
        0: if (check || m_pend != 0) begin m_st <= 1; m_t <= 0; m_pend <= 0; end
        1: begin
          if (check) m_pend <= 1;
          if (m_t == 24) m_st <= 2; else m_t <= m_t + 1;
        end
        2: begin
          if (check) m_pend <= 1;
          if (ships(1) == 0)      begin m_win <= 1; m_st <= 3; m_t <= 0; end
          else if (ships(0) == 0) begin m_win <= 2; m_st <= 3; m_t <= 0; end
          else m_st <= 0;
        end
        3: begin
          if (new_game) m_st <= 5;
          else if (m_t == BC * BT - 1) m_st <= 4;
          else m_t <= m_t + 1;
        end
        4: if (new_game) m_st <= 5;
        default: begin m_pend <= 0; m_st <= 0; end
      endcase
    end
  end

  always @(negedge clk) begin
    int e_row, e_col, e_id, e_en, e_busy, e_go;
    if (cmp_en) begin
      e_row  = (m_st == 1) ? m_t / 5 : 0;
      e_col  = (m_st == 1) ? m_t % 5 : 0;
      e_busy = (m_st == 1 || m_st == 2) ? 1 : 0;
      e_go   = (m_st == 3 || m_st == 4) ? 1 : 0;
      e_en   = (m_st >= 3) ? 1 : 0;
      e_id   = (m_st == 4) ? m_win : (m_st == 3 && ((m_t / BC) % 2) == 0) ? m_win : 0;
      chk("m_row", int'(scan_row), e_row);
      chk("m_col", int'(scan_col), e_col);
      chk("m_busy", int'(busy), e_busy);
      chk("m_game_over", int'(game_over), e_go);
      chk("m_win_en", int'(win_enable), e_en);
      chk("m_win_id", int'(win_id), e_id);
    end
  end

  task automatic drive(input logic c, input logic ng, input logic r);
    @(negedge clk);
    check = c; new_game = ng; rst = r;
  endtask

  task automatic set_board(input bit pc, input int n);
    int placed = 0;
    int idx;
    for (int i = 0; i < 25; i++) begin
      if (pc) pcb[i] = 3'($urandom_range(2, 3)); else pb[i] = 3'($urandom_range(2, 3));
    end
    while (placed < n) begin
      idx = $urandom_range(0, 24);
      if ((pc ? pcb[idx] : pb[idx]) != 3'd1) begin
        if (pc) pcb[idx] = 3'd1; else pb[idx] = 3'd1;
        placed++;
      end
    end
  endtask

  task automatic rand_board(input bit pc);
    logic [2:0] v;
    bool_gen: begin
      int mode = $urandom_range(0, 3);
      for (int i = 0; i < 25; i++) begin
        if (mode != 0 && $urandom_range(0, 3) == 0) v = 3'd1;
        else begin
          v = 3'($urandom_range(0, 2));
          if (v == 3'd1) v = 3'd3;
        end
        if (pc) pcb[i] = v; else pb[i] = v;
      end
    end
  endtask

  // Pulse check with the current boards, capture win_id in cycle 27, then clear.
  task automatic play(input string name, input int exp_id);
    int id27 = -1;
    drive(1, 0, 1);
    for (int i = 1; i <= 30; i++) begin
      drive(0, 0, 1);
      if (i == 27) id27 = int'(win_id);
    end
    chk(name, id27, exp_id);
    drive(0, 1, 1);
    for (int i = 0; i < 3; i++) drive(0, 0, 1);
  endtask

  initial begin
    int busy_cnt, en_cnt, first_en, id27, id31, id51, go51;
    check = 0; new_game = 0; rst = 0;
    set_board(0, 3); set_board(1, 3);
    drive(0, 0, 0);
    cmp_en = 1;
    drive(0, 0, 0);
    drive(0, 0, 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_win_en", int'(win_enable), 0);

    // No winner: 26 busy cycles, display untouched.
    busy_cnt = 0; en_cnt = 0;
    drive(1, 0, 1);
    for (int i = 1; i <= 40; i++) begin
      drive(0, 0, 1);
      if (busy) busy_cnt++;
      if (win_enable) en_cnt++;
    end
    chk("nowin_busy_cycles", busy_cnt, 26);
    chk("nowin_enable_cycles", en_cnt, 0);

    // Player wins: blink then hold.
    set_board(0, 2); set_board(1, 0);
    first_en = 0; id27 = -1; id31 = -1; id51 = -1; go51 = -1;
    drive(1, 0, 1);
    for (int i = 1; i <= 60; i++) begin
      drive(0, 0, 1);
      if (win_enable && first_en == 0) first_en = i;
      if (i == 27) id27 = int'(win_id);
      if (i == 31) id31 = int'(win_id);
      if (i == 51) begin id51 = int'(win_id); go51 = int'(game_over); end
    end
    chk("win_first_enable_cycle", first_en, 27);
    chk("win_id_c27", id27, 1);
    chk("win_id_c31", id31, 0);
    chk("win_id_hold", id51, 1);
    chk("game_over_hold", go51, 1);

    // new_game with check in HOLD: one clear cycle, no rescan.
    drive(1, 1, 1);
    drive(0, 0, 1);
    chk("clear_id", int'(win_id), 0);
    chk("clear_en", int'(win_enable), 1);
    busy_cnt = 0; en_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      drive(0, 0, 1);
      if (busy) busy_cnt++;
      if (win_enable) en_cnt++;
    end
    chk("clear_no_rescan", busy_cnt, 0);
    chk("clear_en_after", en_cnt, 0);

    set_board(0, 0); set_board(1, 1);
    play("pc_wins_id", 2);
    set_board(0, 0); set_board(1, 0);
    play("both_empty_id", 1);

    // Two checks during SCAN collapse into a single rescan.
    set_board(0, 3); set_board(1, 3);
    busy_cnt = 0;
    drive(1, 0, 1);
    for (int i = 1; i <= 80; i++) begin
      drive((i == 5 || i == 12), 0, 1);
      if (busy) busy_cnt++;
    end
    chk("pending_busy_cycles", busy_cnt, 52);

    // Reset mid-scan, then restart from (0,0).
    drive(1, 0, 1);
    for (int i = 1; i <= 10; i++) drive(0, 0, 1);
    drive(0, 0, 0);
    drive(0, 0, 1);
    chk("rst_scan_busy", int'(busy), 0);
    chk("rst_scan_col", int'(scan_col), 0);
    drive(1, 0, 1);
    drive(0, 0, 1);
    chk("restart_col0", int'(scan_col), 0);
    drive(0, 0, 1);
    chk("restart_col1", int'(scan_col), 1);
    for (int i = 0; i < 30; i++) drive(0, 0, 1);

    // Reset in SHOW cycle 3.
    set_board(0, 2); set_board(1, 0);
    drive(1, 0, 1);
    for (int i = 1; i <= 29; i++) drive(0, 0, 1);
    drive(0, 0, 0);
    drive(0, 0, 1);
    chk("rst_show_en", int'(win_enable), 0);
    chk("rst_show_go", int'(game_over), 0);
    chk("rst_show_id", int'(win_id), 0);
    for (int i = 0; i < 5; i++) drive(0, 0, 1);

    // Random traffic; boards only change while the controller is idle.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (m_st == 0 && $urandom_range(0, 3) == 0) begin
        rand_board(0); rand_board(1);
      end
      drive($urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0, $urandom_range(0, 299) != 0);
    end
    drive(0, 0, 1);
    cmp_en = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
